// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory handshake plus datapath retire/control bundle.
interface fetch_unit_if #(parameter int CNT_W = 32);
   logic [31:0]      imem_addr;
   logic             imem_req;
   logic             imem_ready;
   logic [31:0]      imem_rdata;
   logic [31:0]      instr;
   logic             instr_valid;
   logic [31:0]      pcplus4;
   logic             retire;
   logic             stall;
   logic             pcsrc;
   logic             jump;
   logic             jr;
   logic [31:0]      signimm;
   logic [31:0]      jr_target;
   logic             misalign;
   logic [CNT_W-1:0] retired_count;
   modport master (
      output imem_addr, imem_req, instr, instr_valid, pcplus4, misalign, retired_count,
      input  imem_ready, imem_rdata, retire, stall, pcsrc, jump, jr, signimm, jr_target
   );
   modport slave (
      input  imem_addr, imem_req, instr, instr_valid, pcplus4, misalign, retired_count,
      output imem_ready, imem_rdata, retire, stall, pcsrc, jump, jr, signimm, jr_target
   );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: holds the PC, fetches one instruction at a time and picks the next PC on retire.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input logic          clk,
   input logic          reset,
   fetch_unit_if.master bus
);
   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
   state_t           state, state_nx;
   logic [31:0]      pc, pc4, next_pc, instr_q;
   logic [CNT_W-1:0] cnt;
   logic             mis, fire;
   assign pc4  = pc + 32'd4;
   assign fire = (state == HOLD) & bus.retire & ~bus.stall;
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else       state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = FETCH;
         FETCH:   state_nx = bus.imem_ready ? HOLD : FETCH;
         HOLD:    state_nx = fire ? FETCH : HOLD;
         default: state_nx = IDLE;
      endcase
   end
   always_comb begin
      bus.imem_req    = (state == FETCH);
      bus.instr_valid = (state == HOLD);
   end
   // jr beats jump beats branch; jr targets are forced word-aligned even when flagged
   assign next_pc = bus.jr    ? {bus.jr_target[31:2], 2'b00} :
                    bus.jump  ? {pc4[31:28], instr_q[25:0], 2'b00} :
                    bus.pcsrc ? pc4 + (bus.signimm << 2) : pc4;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         pc      <= RESET_PC;
         instr_q <= '0;
         mis     <= 1'b0;
         cnt     <= '0;
      end else begin
         if (bus.imem_req & bus.imem_ready) instr_q <= bus.imem_rdata;
         if (fire) begin
            pc  <= next_pc;
            cnt <= cnt + CNT_W'(1);
            mis <= mis | (bus.jr & (|bus.jr_target[1:0]));
         end
      end
   assign bus.imem_addr     = pc;
   assign bus.pcplus4       = pc4;
   assign bus.instr         = instr_q;
   assign bus.misalign      = mis;
   assign bus.retired_count = cnt;
endmodule
